// File: rtl/pb_debounce.sv
// pb_debounce: per-key synchronizer + counter debouncer with press/release strobes.
// Define PB_RELEASE_EN to build the pb_release strobe logic; otherwise pb_release is tied to 0.
module pb_debounce #(
  parameter int NUM_KEYS   = 16,
  parameter int DEB_CYCLES = 10000,
  parameter int CNT_W      = 14
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_KEYS-1:0] pb,
  output logic [NUM_KEYS-1:0] pb_db,
  output logic [NUM_KEYS-1:0] pb_press,
  output logic [NUM_KEYS-1:0] pb_release
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);
  logic [NUM_KEYS-1:0] s1, s2, hit;
  logic [NUM_KEYS-1:0][CNT_W-1:0] cnt, cnt_nxt;
  // hit marks the edge on which a key's new level has been stable long enough
  always_comb begin
    hit = '0;
    cnt_nxt = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      hit[i] = (s2[i] != pb_db[i]) && (cnt[i] == LAST);
      cnt_nxt[i] = (s2[i] == pb_db[i] || hit[i]) ? '0 : cnt[i] + CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1 <= '0;
      s2 <= '0;
      cnt <= '0;
      pb_db <= '0;
      pb_press <= '0;
    end else begin
      s1 <= pb;
      s2 <= s1;
      cnt <= cnt_nxt;
      pb_db <= pb_db ^ hit;
      pb_press <= hit & s2;
    end
  end
`ifdef PB_RELEASE_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) pb_release <= '0;
    else pb_release <= hit & ~s2;
  end
`else
  assign pb_release = '0;
`endif
endmodule

// File: tb/tb_pb_debounce.sv
// tb_pb_debounce: directed checks of pb_debounce with NUM_KEYS=16, DEB_CYCLES=4.
module tb_pb_debounce;
  logic clk = 1'b0;
  logic n_rst;
  logic [15:0] pb, pb_db, pb_press, pb_release;
  int vectors = 0;
  int errs = 0;
  logic [15:0] rel_exp;
  pb_debounce #(.NUM_KEYS(16), .DEB_CYCLES(4), .CNT_W(14)) dut (
    .clk(clk), .n_rst(n_rst), .pb(pb), .pb_db(pb_db),
    .pb_press(pb_press), .pb_release(pb_release)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [15:0] db, input logic [15:0] pr, input logic [15:0] rl);
    chk({tag, ".db"}, pb_db, db);
    chk({tag, ".press"}, pb_press, pr);
    chk({tag, ".release"}, pb_release, rl);
  endtask
  initial begin
`ifdef PB_RELEASE_EN
    rel_exp = 16'h8000;
`else
    rel_exp = 16'h0000;
`endif
    n_rst = 1'b0;
    pb = 16'h0000;
    #12;
    chk_all("reset", 16'h0000, 16'h0000, 16'h0000);
    n_rst = 1'b1;
    tick(3);
    chk_all("idle", 16'h0000, 16'h0000, 16'h0000);
    // single press on key 15: tick n lands just after edge k+n-1
    pb = 16'h8000;
    tick(5);
    chk_all("press_early", 16'h0000, 16'h0000, 16'h0000);
    tick(1);
    chk_all("press_edge", 16'h8000, 16'h8000, 16'h0000);
    chk("press_cnt15", 16'(dut.cnt[15]), 16'h0000);
    tick(1);
    chk_all("press_after", 16'h8000, 16'h0000, 16'h0000);
    tick(3);
    chk_all("press_hold", 16'h8000, 16'h0000, 16'h0000);
    pb = 16'h0000;
    tick(5);
    chk_all("rel_early", 16'h8000, 16'h0000, 16'h0000);
    tick(1);
    chk_all("rel_edge", 16'h0000, 16'h0000, rel_exp);
    tick(1);
    chk_all("rel_after", 16'h0000, 16'h0000, 16'h0000);
    tick(3);
    // glitch train: 3-cycle highs with 1-cycle gaps never settle
    for (int r = 0; r < 5; r++) begin
      pb = 16'h8000;
      for (int c = 0; c < 3; c++) begin
        tick(1);
        chk("glitch.db", pb_db, 16'h0000);
        chk("glitch.press", pb_press, 16'h0000);
      end
      pb = 16'h0000;
      tick(1);
      chk("glitch_gap.db", pb_db, 16'h0000);
      chk("glitch_gap.press", pb_press, 16'h0000);
    end
    for (int c = 0; c < 6; c++) begin
      tick(1);
      chk("glitch_tail.db", pb_db, 16'h0000);
      chk("glitch_tail.press", pb_press, 16'h0000);
    end
    // two keys, bit1 two cycles behind bit0
    pb = 16'h0001;
    for (int t = 1; t <= 9; t++) begin
      tick(1);
      if (t == 2) pb = 16'h0003;
      chk("two_key.press", pb_press, t == 6 ? 16'h0001 : t == 8 ? 16'h0002 : 16'h0000);
      chk("two_key.db", pb_db, t < 6 ? 16'h0000 : t < 8 ? 16'h0001 : 16'h0003);
    end
    // reset mid-count with key 15 held
    pb = 16'h8000;
    tick(3);
    chk("pre_rst.db", pb_db, 16'h0003);
    #2 n_rst = 1'b0;
    #1;
    chk_all("async_rst", 16'h0000, 16'h0000, 16'h0000);
    chk("async_rst.cnt15", 16'(dut.cnt[15]), 16'h0000);
    @(negedge clk);
    n_rst = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick(1);
      chk("post_rst.db", pb_db, t < 6 ? 16'h0000 : 16'h8000);
      chk("post_rst.press", pb_press, t == 6 ? 16'h8000 : 16'h0000);
      chk("post_rst.release", pb_release, 16'h0000);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
